// File: rtl/uart_cmd_responder.sv
// DUT-side end of the remote command link: 8N1 receiver that frames two bytes
// (high first) into a 16-bit command, plus an 8N1 transmitter for the response byte.
module uart_cmd_responder #(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned BYTE_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
  localparam int unsigned TO_W  = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [TO_W-1:0]  TO_END   = TO_W'(BYTE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // receive side state
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e      rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_brk_q;

  // framing state
  logic             phase_lo_q;
  logic [7:0]       hold_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [15:0]      cmd_q;
  logic             cmd_rdy_q;
  logic             frm_err_q;

  // transmit side state
  uart_state_e      tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;
  logic             tx_busy_q;
  logic             tx_done_q;

  logic start_edge, stop_smp, byte_ok, stop_bad, timeout;

  always_comb begin
    start_edge = (rx_state_q == S_IDLE) && rx_prev_q && !rx_sync_q;
    stop_smp   = (rx_state_q == S_STOP) && !rx_brk_q && (rx_cnt_q == BIT_END);
    byte_ok    = stop_smp && rx_sync_q;
    stop_bad   = stop_smp && !rx_sync_q;
    timeout    = phase_lo_q && (rx_state_q == S_IDLE) && !start_edge &&
                 (to_cnt_q == TO_END);
  end

  // RX synchroniser and bit-level receive FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_state_q)
        S_IDLE: begin
          if (start_edge) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          // after a bad stop bit, hold here until the line returns high
          if (rx_brk_q) begin
            if (rx_sync_q) begin
              rx_brk_q   <= 1'b0;
              rx_state_q <= S_IDLE;
            end
          end else if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) rx_state_q <= S_IDLE;
            else           rx_brk_q   <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // two-byte command framing, inter-byte timeout and cmd_rdy handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_lo_q <= 1'b0;
      hold_q     <= '0;
      to_cnt_q   <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      frm_err_q <= 1'b0;
      if (byte_ok) begin
        if (!phase_lo_q) begin
          hold_q     <= rx_shift_q;
          phase_lo_q <= 1'b1;
          to_cnt_q   <= '0;
        end else begin
          cmd_q      <= {hold_q, rx_shift_q};
          phase_lo_q <= 1'b0;
        end
      end else if (stop_bad || timeout) begin
        frm_err_q  <= 1'b1;
        phase_lo_q <= 1'b0;
      end else if (phase_lo_q && (rx_state_q == S_IDLE) && !start_edge) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      // a completion outranks any clear in the same cycle
      if (byte_ok && phase_lo_q) begin
        cmd_rdy_q <= 1'b1;
      end else if (clr_cmd_rdy || (start_edge && !phase_lo_q)) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  // transmit FSM; each bit, including start and stop, lasts BAUD_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (trmt) begin
            tx_shift_q <= resp;
            tx_busy_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_q       <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b1;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign TX      = tx_q;
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign tx_done = tx_done_q;
  assign tx_busy = tx_busy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with BAUD_DIV=16, BYTE_TIMEOUT=400.
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt = 1'b0;
  logic        tx_done;
  logic        tx_busy;
  logic        frm_err;

  int n_checks = 0;
  int n_errs   = 0;
  int frm_cnt  = 0;
  int frm_base;

  uart_cmd_responder #(.BAUD_DIV(16), .BYTE_TIMEOUT(400)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt),
    .tx_done(tx_done), .tx_busy(tx_busy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frm_err === 1'b1) frm_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 1: check cmd_rdy timing around the stop sample
  // mode 2: pulse clr_cmd_rdy on the completion cycle
  // mode 3: assert rst during data bit 3 and leave it asserted
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int mode);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      RX = fr[j];
      if (mode == 3 && j == 4) rst = 1'b1;
      for (int n = 1; n <= 16; n++) begin
        @(negedge clk);
        if (j == 9 && mode == 1 && n == 9)  check("rdy_early", 32'(cmd_rdy), 32'd0);
        if (j == 9 && mode == 1 && n == 12) check("rdy_late", 32'(cmd_rdy), 32'd1);
        if (j == 9 && mode == 2 && n == 10) clr_cmd_rdy = 1'b1;
        if (j == 9 && mode == 2 && n == 11) clr_cmd_rdy = 1'b0;
        if (j == 9 && mode == 2 && n == 12) check("set_wins", 32'(cmd_rdy), 32'd1);
      end
    end
    RX = 1'b1;
    idle(16);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_byte;
    logic       exp_tx;
    int         bi;

    // reset values
    idle(3);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ferr", 32'(frm_err), 32'd0);
    rst = 1'b0;
    idle(4);

    // basic two-byte command
    send_frame(8'h2A, 1'b1, 0);
    send_frame(8'h5C, 1'b1, 1);
    check("cmd_2a5c", 32'(cmd), 32'h2A5C);
    check("rdy_2a5c", 32'(cmd_rdy), 32'd1);
    check("ferr_none", 32'(frm_cnt), 32'd0);
    pulse_clr();
    check("rdy_clr", 32'(cmd_rdy), 32'd0);
    check("cmd_hold", 32'(cmd), 32'h2A5C);

    // transmit 0xA5; a second trmt mid-frame must be ignored
    exp_byte = 8'hA5;
    resp = 8'hA5;
    trmt = 1'b1;
    for (int n = 1; n <= 172; n++) begin
      @(negedge clk);
      if (n == 1) trmt = 1'b0;
      if (n == 50) begin resp = 8'h00; trmt = 1'b1; end
      if (n == 51) trmt = 1'b0;
      bi = (n - 1) / 16;
      if (bi == 0)      exp_tx = 1'b0;
      else if (bi <= 8) exp_tx = exp_byte[3'(bi - 1)];
      else              exp_tx = 1'b1;
      check($sformatf("tx_bit%0d_c%0d", bi, n), 32'(TX), 32'(exp_tx));
      check($sformatf("tx_busy_c%0d", n), 32'(tx_busy), 32'((n - 1) < 160));
      check($sformatf("tx_done_c%0d", n), 32'(tx_done), 32'((n - 1) >= 160));
    end

    // bad stop bit on the low byte
    frm_base = frm_cnt;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h77, 1'b0, 0);
    check("ferr_stop", 32'(frm_cnt - frm_base), 32'd1);
    check("rdy_after_ferr", 32'(cmd_rdy), 32'd0);
    check("cmd_after_ferr", 32'(cmd), 32'h2A5C);
    check("done_sticky", 32'(tx_done), 32'd1);
    send_frame(8'h34, 1'b1, 0);
    send_frame(8'h56, 1'b1, 0);
    check("cmd_3456_a", 32'(cmd), 32'h3456);
    check("rdy_3456_a", 32'(cmd_rdy), 32'd1);
    pulse_clr();

    // inter-byte timeout
    frm_base = frm_cnt;
    send_frame(8'h12, 1'b1, 0);
    idle(500);
    check("ferr_timeout", 32'(frm_cnt - frm_base), 32'd1);
    check("rdy_timeout", 32'(cmd_rdy), 32'd0);
    send_frame(8'h34, 1'b1, 0);
    send_frame(8'h56, 1'b1, 0);
    check("cmd_3456_b", 32'(cmd), 32'h3456);
    check("rdy_3456_b", 32'(cmd_rdy), 32'd1);
    pulse_clr();

    // short glitch is a false start; then completion coincides with clear
    frm_base = frm_cnt;
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(60);
    check("glitch_ferr", 32'(frm_cnt - frm_base), 32'd0);
    check("glitch_rdy", 32'(cmd_rdy), 32'd0);
    send_frame(8'hBE, 1'b1, 0);
    send_frame(8'hEF, 1'b1, 2);
    check("cmd_beef", 32'(cmd), 32'hBEEF);
    check("rdy_beef", 32'(cmd_rdy), 32'd1);

    // reset in the middle of the second byte
    frm_base = frm_cnt;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 3);
    check("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    check("mid_rst_tx", 32'(TX), 32'd1);
    check("mid_rst_cmd", 32'(cmd), 32'h0);
    check("mid_rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    idle(32);
    send_frame(8'hC0, 1'b1, 0);
    send_frame(8'h01, 1'b1, 0);
    check("cmd_c001", 32'(cmd), 32'hC001);
    check("rdy_c001", 32'(cmd_rdy), 32'd1);
    check("ferr_rst", 32'(frm_cnt - frm_base), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
